uart_rx_fifo: RTL and testbench

Synthesizable UART receiver with a receive FIFO, sitting between an external serial RX pin and a CPU-side register interface. It detects start bits, samples each bit at its mid-point, checks parity and the stop bit, and queues good bytes in a show-ahead FIFO. Parity, framing and overrun conditions are reported as sticky flags.

---
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, parity/stop check, show-ahead byte FIFO.
// Latency: a good byte is visible in the FIFO one cycle after its stop-bit sample; rd pops on the next edge.
// Backpressure: none on the line; a byte arriving at a full FIFO with no same-cycle pop is dropped (overrun).
// Ports: clk / reset (synchronous, active high); rx serial input (idles high);
//        rd, rdata, empty, full, count form the CPU side of the FIFO;
//        parity_err, frame_err, overrun are sticky flags cleared by clr_err (a same-cycle set wins).
module uart_rx_fifo #(
  parameter int clks_per_bit = 434,
  parameter int data_bits    = 8,
  parameter int parity_bit   = 0,
  parameter int parity_odd   = 0,
  parameter int fifo_log2    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd,
  output logic [7:0]           rdata,
  output logic                 empty,
  output logic                 full,
  output logic [fifo_log2:0]   count,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam int                 CW       = $clog2(clks_per_bit);
  localparam int                 DEPTH    = 1 << fifo_log2;
  localparam logic [CW-1:0]      HALF_M1  = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0]      FULL_M1  = CW'(clks_per_bit - 1);
  localparam logic [2:0]         LAST_BIT = 3'(data_bits - 1);
  localparam logic               PAR_EN   = (parity_bit != 0);
  localparam logic               PAR_ODD  = (parity_odd != 0);
  localparam logic [fifo_log2:0] DEPTH_C  = (fifo_log2 + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  // Synchroniser and edge history. All reset high so an idle line produces no edge.
  logic rx_meta_q, rx_s_q, rx_p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_p_q    <= rx_s_q;
    end
  end

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;

  logic fall, tick;
  assign fall = rx_p_q & ~rx_s_q;
  assign tick = (cnt_q == '0);

  // cnt_q counts down to the next sample point; every sample reloads a full bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (!tick) cnt_q <= cnt_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q <= S_START;
            cnt_q   <= HALF_M1;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              cnt_q   <= FULL_M1;
              bit_q   <= '0;
              par_q   <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            // Shift in from the top; the byte is right-justified when it is pushed.
            shift_q <= {rx_s_q, shift_q[7:1]};
            par_q   <= par_q ^ rx_s_q;
            cnt_q   <= FULL_M1;
            if (bit_q == LAST_BIT) state_q <= PAR_EN ? S_PARITY : S_STOP;
            else                   bit_q   <= bit_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick) begin
            par_q   <= par_q ^ rx_s_q;
            cnt_q   <= FULL_M1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) state_q <= rx_s_q ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          // A held-low line must go high before another start bit can be seen.
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic       stop_smp, push, frame_set, par_bad;
  logic [7:0] rx_byte;
  assign stop_smp  = (state_q == S_STOP) && tick;
  assign push      = stop_smp && rx_s_q;
  assign frame_set = stop_smp && !rx_s_q;
  assign par_bad   = PAR_EN && (par_q != PAR_ODD);
  assign rx_byte   = shift_q >> (8 - data_bits);

  // FIFO
  logic [7:0]           mem_q [DEPTH];
  logic [fifo_log2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [fifo_log2:0]   count_q, count_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 is_empty, is_full, pop, wr_en;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign pop      = rd && !is_empty;
  // A full FIFO still accepts a byte when the head is leaving in the same cycle.
  assign wr_en    = push && (!is_full || pop);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_en) wp_d = wp_q + 1'b1;
    if (pop)   rp_d = rp_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    perr_d = (perr_q & ~clr_err) | (push & par_bad);
    ferr_d = (ferr_q & ~clr_err) | frame_set;
    ovr_d  = (ovr_q  & ~clr_err) | (push & is_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= rx_byte;
  end

  assign rdata      = is_empty ? 8'h00 : mem_q[rp_q];
  assign empty      = is_empty;
  assign full       = is_full;
  assign count      = count_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 instance (a) and an 8E1 instance (b), both at 8 clocks per bit.
module tb_uart_rx_fifo;
  localparam int CPB = 8;

  logic       clk, reset;
  logic       rx_a, rd_a, clr_a, empty_a, full_a, perr_a, ferr_a, ovr_a;
  logic [7:0] rdata_a;
  logic [4:0] count_a;
  logic       rx_b, rd_b, clr_b, empty_b, full_b, perr_b, ferr_b, ovr_b;
  logic [7:0] rdata_b;
  logic [4:0] count_b;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_fifo #(.clks_per_bit(CPB), .data_bits(8), .parity_bit(0), .parity_odd(0), .fifo_log2(4)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .rd(rd_a), .rdata(rdata_a), .empty(empty_a),
    .full(full_a), .count(count_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .clr_err(clr_a));

  uart_rx_fifo #(.clks_per_bit(CPB), .data_bits(8), .parity_bit(1), .parity_odd(0), .fifo_log2(4)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .rd(rd_b), .rdata(rdata_b), .empty(empty_b),
    .full(full_b), .count(count_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .clr_err(clr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All line tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input int which, input logic v, input int cycles);
    if (which == 0) rx_a = v; else rx_b = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input int which, input logic [7:0] b, input int nbits);
    drive_bit(which, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(which, b[i], CPB);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input bit has_par,
                            input logic par, input logic stop);
    send_head(which, b, 8);
    if (has_par) drive_bit(which, par, CPB);
    drive_bit(which, stop, CPB);
  endtask

  task automatic pop_a();
    rd_a = 1'b1;
    @(posedge clk);
    #1 rd_a = 1'b0;
  endtask

  task automatic do_reset();
    rx_a = 1'b1; rx_b = 1'b1; rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rx_a = 1'b1; rx_b = 1'b1; rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({empty_a, full_a, count_a, rdata_a} !== {1'b1, 1'b0, 5'd0, 8'h00})
      $display("FAIL reset_fifo_a: got e=%b f=%b c=%0d d=%h want e=1 f=0 c=0 d=00", empty_a, full_a, count_a, rdata_a);
    else n_pass++;
    n_checks++; if ({perr_a, ferr_a, ovr_a} !== 3'b000)
      $display("FAIL reset_flags_a: got %b want 000", {perr_a, ferr_a, ovr_a});
    else n_pass++;
    n_checks++; if ({empty_b, count_b, perr_b, ferr_b, ovr_b} !== {1'b1, 5'd0, 3'b000})
      $display("FAIL reset_b: got e=%b c=%0d flags=%b want e=1 c=0 flags=000", empty_b, count_b, {perr_b, ferr_b, ovr_b});
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Start bit lands after edge P0; the stop bit is sampled on edge P0+79.
  task automatic test_single();
    do_reset();
    send_head(0, 8'hA5, 8);
    rx_a = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++; if (empty_a !== 1'b1) $display("FAIL single_empty_before: got %b want 1", empty_a); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (empty_a !== 1'b0) $display("FAIL single_empty_after: got %b want 0", empty_a); else n_pass++;
    n_checks++; if (rdata_a !== 8'hA5) $display("FAIL single_rdata: got %h want a5", rdata_a); else n_pass++;
    n_checks++; if (count_a !== 5'd1) $display("FAIL single_count: got %0d want 1", count_a); else n_pass++;
    rd_a = 1'b1;
    @(posedge clk);
    #1 rd_a = 1'b0;
    @(negedge clk);
    n_checks++; if ({empty_a, rdata_a} !== {1'b1, 8'h00})
      $display("FAIL single_pop: got e=%b d=%h want e=1 d=00", empty_a, rdata_a);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if ({full_a, count_a, ovr_a} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL b2b_full: got f=%b c=%0d ovr=%b want f=1 c=16 ovr=1", full_a, count_a, ovr_a);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++; if (rdata_a !== 8'(i)) $display("FAIL b2b_read%0d: got %h want %h", i, rdata_a, 8'(i)); else n_pass++;
      pop_a();
    end
    @(negedge clk);
    n_checks++; if ({empty_a, count_a} !== {1'b1, 5'd0})
      $display("FAIL b2b_drained: got e=%b c=%0d want e=1 c=0", empty_a, count_a);
    else n_pass++;
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    @(negedge clk);
    n_checks++; if (ovr_a !== 1'b0) $display("FAIL b2b_clr_overrun: got %b want 0", ovr_a); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // 8'h07 has three ones: even parity bit is 1; sending 0 is a parity error.
  task automatic test_parity();
    do_reset();
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if ({count_b, rdata_b, perr_b} !== {5'd1, 8'h07, 1'b0})
      $display("FAIL parity_good: got c=%0d d=%h perr=%b want c=1 d=07 perr=0", count_b, rdata_b, perr_b);
    else n_pass++;
    @(posedge clk);
    #1;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if ({count_b, perr_b, ferr_b} !== {5'd2, 1'b1, 1'b0})
      $display("FAIL parity_bad: got c=%0d perr=%b ferr=%b want c=2 perr=1 ferr=0", count_b, perr_b, ferr_b);
    else n_pass++;
    rd_b = 1'b1;
    @(posedge clk);
    #1 rd_b = 1'b0;
    @(negedge clk);
    n_checks++; if ({count_b, rdata_b} !== {5'd1, 8'h07})
      $display("FAIL parity_second_byte: got c=%0d d=%h want c=1 d=07", count_b, rdata_b);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_break();
    do_reset();
    send_head(0, 8'h3C, 8);
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b0, 5 * CPB);
    @(negedge clk);
    n_checks++; if ({empty_a, count_a, ferr_a} !== {1'b1, 5'd0, 1'b1})
      $display("FAIL break_low: got e=%b c=%0d ferr=%b want e=1 c=0 ferr=1", empty_a, count_a, ferr_a);
    else n_pass++;
    @(posedge clk);
    #1;
    drive_bit(0, 1'b1, 4 * CPB);
    @(negedge clk);
    n_checks++; if ({empty_a, ferr_a, perr_a} !== {1'b1, 1'b1, 1'b0})
      $display("FAIL break_release: got e=%b ferr=%b perr=%b want e=1 ferr=1 perr=0", empty_a, ferr_a, perr_a);
    else n_pass++;
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    @(negedge clk);
    n_checks++; if (ferr_a !== 1'b0) $display("FAIL break_clr: got %b want 0", ferr_a); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_glitch();
    do_reset();
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 4 * CPB);
    @(negedge clk);
    n_checks++; if ({empty_a, perr_a, ferr_a, ovr_a} !== 4'b1000)
      $display("FAIL glitch: got e=%b flags=%b want e=1 flags=000", empty_a, {perr_a, ferr_a, ovr_a});
    else n_pass++;
    @(posedge clk);
    #1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if ({count_a, rdata_a} !== {5'd1, 8'h5A})
      $display("FAIL glitch_next_frame: got c=%0d d=%h want c=1 d=5a", count_a, rdata_a);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(0, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
    send_head(0, 8'h55, 8);
    rx_a = 1'b1;
    repeat (6) @(posedge clk);
    #1 rd_a = 1'b1;
    @(posedge clk);
    #1 rd_a = 1'b0;
    @(negedge clk);
    n_checks++; if ({count_a, full_a, ovr_a} !== {5'd16, 1'b1, 1'b0})
      $display("FAIL simul_full: got c=%0d f=%b ovr=%b want c=16 f=1 ovr=0", count_a, full_a, ovr_a);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      n_checks++; if (rdata_a !== 8'h40 + 8'(i))
        $display("FAIL simul_read%0d: got %h want %h", i, rdata_a, 8'h40 + 8'(i));
      else n_pass++;
      pop_a();
    end
    @(negedge clk);
    n_checks++; if (rdata_a !== 8'h55) $display("FAIL simul_last: got %h want 55", rdata_a); else n_pass++;
    pop_a();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if ({count_a, ferr_a} !== {5'd1, 1'b1})
      $display("FAIL rmid_setup: got c=%0d ferr=%b want c=1 ferr=1", count_a, ferr_a);
    else n_pass++;
    @(posedge clk);
    #1;
    send_head(0, 8'h00, 3);
    rx_a = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({empty_a, full_a, count_a, rdata_a, perr_a, ferr_a, ovr_a} !== {1'b1, 1'b0, 5'd0, 8'h00, 3'b000})
      $display("FAIL rmid_reset: got e=%b f=%b c=%0d d=%h flags=%b want e=1 f=0 c=0 d=00 flags=000",
               empty_a, full_a, count_a, rdata_a, {perr_a, ferr_a, ovr_a});
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if ({count_a, rdata_a, ferr_a} !== {5'd1, 8'hC3, 1'b0})
      $display("FAIL rmid_next_frame: got c=%0d d=%h ferr=%b want c=1 d=c3 ferr=0", count_a, rdata_a, ferr_a);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_break();
    test_glitch();
    test_full_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
